fetch_line_unit: RTL and testbench
==================================

FETCH_LINE_UNIT -- requirements
Module: fetch_line_unit

Interface
REQ-001 Parameters SHALL be: ID_WIDTH, default 13, AXI ID width; ADDR_WIDTH, default 64, address width; DATA_WIDTH, default 64, AXI data width (only 64 supported).
REQ-002 clk  input  1  sole clock; all state changes on rising edge.
REQ-003 reset  input  1  asynchronous, active-low reset.
REQ-004 entry  input  64  program entry PC, sampled on leaving reset.
REQ-005 redirect_valid  input  1  branch/jump redirect request from execute.
REQ-006 redirect_pc  input  64  redirect target; bits [1:0] ignored (treated as 0).
REQ-007 out_valid  output  1  out_instr/out_pc valid toward the IF/ID register.
REQ-008 out_ready  input  1  consumer accepts; a transfer occurs on out_valid & out_ready.
REQ-009 out_instr  output  32  fetched instruction.
REQ-010 out_pc  output  64  address of out_instr.
REQ-011 fetch_error  output  1  high while the fetch unit is stalled on a bus error.
REQ-012 m_axi_arid[ID_WIDTH], araddr[ADDR_WIDTH], arlen[8], arsize[3], arburst[2], arvalid[1]  output  AXI read-address channel; arready  input  1.
REQ-013 m_axi_rid[ID_WIDTH], rdata[64], rresp[2], rlast[1], rvalid[1]  input; rready  output  1  AXI read-data channel.

Function
REQ-014 States SHALL be INIT, LOOKUP, AR, R, HOLD, AR_KILL, DRAIN, ERR.
REQ-015 Line buffer SHALL hold line_valid, line_tag (PC[63:3]), line_data (64 bits); hit = line_valid & line_tag == pc[63:3].
REQ-016 INIT: one cycle after reset release; pc <= {entry[63:2],2'b00}; -> LOOKUP.
REQ-017 LOOKUP: hit -> load out_instr (pc[2] ? line_data[63:32] : line_data[31:0]), out_pc <= pc, -> HOLD; miss -> AR.
REQ-018 AR: arvalid=1, araddr={pc[63:3],3'b000}, arlen=0, arsize=3'b011, arburst=2'b01, arid=0; araddr stable while arvalid; arready -> R.
REQ-019 R: rready=1; rvalid & rresp==0 -> fill line buffer, load outputs per REQ-017, -> HOLD; rvalid & rresp!=0 -> line_valid <= 0, -> ERR.
REQ-020 HOLD: out_valid=1; on transfer pc <= pc+4 (64-bit modulo wrap); if pc[2]==0, load upper word with out_pc <= pc+4, stay HOLD (back-to-back, 1 instr/cycle); else -> LOOKUP.
REQ-021 Miss latency: out_valid SHALL assert exactly 1 cycle after the rvalid beat; hit from LOOKUP: 1 cycle.
REQ-022 Exactly one AXI read outstanding at any time; rid and rlast not checked (single-beat).
REQ-023 Redirect SHALL take priority over every other event; pc <= redirect_pc in all states except INIT.
REQ-024 Redirect in LOOKUP/HOLD/ERR: -> LOOKUP; out_valid low next cycle; a simultaneous out_ready transfer is discarded by the consumer and SHALL NOT advance pc.
REQ-025 Redirect in AR: arvalid and araddr held until arready (no AXI withdrawal); -> AR_KILL.
REQ-026 AR_KILL: arvalid=1 with old address; arready -> DRAIN.
REQ-027 Redirect in R: rvalid same cycle -> beat discarded, no fill, -> LOOKUP; else -> DRAIN.
REQ-028 DRAIN: rready=1; beat discarded (no fill, no error); rvalid -> LOOKUP; further redirects update pc only.
REQ-029 ERR: out_valid=0, fetch_error=1; leaves only on redirect.
REQ-030 Redirect never invalidates the line buffer; a redirect into the buffered line SHALL hit.

Reset
REQ-031 reset low SHALL immediately force state INIT, out_valid=0, out_instr=0, out_pc=0, fetch_error=0, arvalid=0, rready=0, araddr=0, line_valid=0, pc=0, asynchronously, including mid-transaction.
REQ-032 arlen, arsize, arburst, arid SHALL be constant 0, 3'b011, 2'b01, 0.

Verification
REQ-033 entry=0x8000_0000, memory[0x8000_0000]=0x0000_0013_0000_0093, out_ready=1 -> one AR at 0x8000_0000; out 0x00000093@0x80000000 then 0x00000013@0x80000004 on the next cycle; next AR at 0x8000_0008.
REQ-034 arready held low 5 cycles -> arvalid and araddr stable all 5 cycles; out_valid rises 1 cycle after the rvalid beat.
REQ-035 Redirect to 0x8000_0100 in the AR cycle before arready -> old read completes, its data discarded, next AR at 0x8000_0100, first out_pc=0x8000_0100.
REQ-036 rresp=2'b10 -> fetch_error=1, out_valid=0 indefinitely; redirect to 0x8000_0004 (buffered line invalid) -> fetch_error=0, new AR at 0x8000_0000, out_pc=0x8000_0004.
REQ-037 out_ready low 10 cycles in HOLD -> out_instr/out_pc unchanged, no AR issued; redirect to 0x8000_0004 while line 0x8000_0000 valid -> no AR, out_pc=0x8000_0004 after 1 cycle.
REQ-038 reset pulsed low while in R -> arvalid/rready/out_valid low same cycle; after release, INIT reloads entry and refetches.

Source files
------------

// File: rtl/fetch_line_unit.sv
// Instruction fetch unit with a single-line (64-bit) buffer and an AXI read master.
// Fetches one aligned 64-bit line per miss, then streams both 32-bit words from the
// buffer to the IF/ID register. Redirects always win; reads already issued on AXI are
// completed and their data dropped.
module fetch_line_unit #(
  parameter int unsigned ID_WIDTH   = 13,
  parameter int unsigned ADDR_WIDTH = 64,
  parameter int unsigned DATA_WIDTH = 64
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [63:0]           entry,
  input  logic                  redirect_valid,
  input  logic [63:0]           redirect_pc,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [31:0]           out_instr,
  output logic [63:0]           out_pc,
  output logic                  fetch_error,
  output logic [ID_WIDTH-1:0]   m_axi_arid,
  output logic [ADDR_WIDTH-1:0] m_axi_araddr,
  output logic [7:0]            m_axi_arlen,
  output logic [2:0]            m_axi_arsize,
  output logic [1:0]            m_axi_arburst,
  output logic                  m_axi_arvalid,
  input  logic                  m_axi_arready,
  input  logic [ID_WIDTH-1:0]   m_axi_rid,
  input  logic [DATA_WIDTH-1:0] m_axi_rdata,
  input  logic [1:0]            m_axi_rresp,
  input  logic                  m_axi_rlast,
  input  logic                  m_axi_rvalid,
  output logic                  m_axi_rready
);

  typedef enum logic [2:0] {
    StInit,
    StLookup,
    StAr,
    StR,
    StHold,
    StArKill,
    StDrain,
    StErr
  } state_e;

  state_e                state_q, state_d;
  logic [63:0]           pc_q, pc_d;
  logic                  line_valid_q, line_valid_d;
  logic [60:0]           line_tag_q, line_tag_d;
  logic [63:0]           line_data_q, line_data_d;
  logic [31:0]           out_instr_q, out_instr_d;
  logic [63:0]           out_pc_q, out_pc_d;
  logic [ADDR_WIDTH-1:0] araddr_q, araddr_d;

  logic        hit;
  logic [63:0] redirect_target;
  logic [63:0] pc_plus4;

  // Single-beat reads: rid/rlast carry no information; low PC bits are always zero.
  logic unused_inputs;
  assign unused_inputs = ^{m_axi_rid, m_axi_rlast, redirect_pc[1:0], entry[1:0]};

  assign hit             = line_valid_q && (line_tag_q == pc_q[63:3]);
  assign redirect_target = {redirect_pc[63:2], 2'b00};
  assign pc_plus4        = pc_q + 64'd4;

  // Next-state, PC and line-buffer update; redirect is checked first in every state
  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    line_valid_d = line_valid_q;
    line_tag_d   = line_tag_q;
    line_data_d  = line_data_q;
    out_instr_d  = out_instr_q;
    out_pc_d     = out_pc_q;
    araddr_d     = araddr_q;

    unique case (state_q)
      StInit: begin
        pc_d    = {entry[63:2], 2'b00};
        state_d = StLookup;
      end
      StLookup: begin
        if (redirect_valid) begin
          pc_d = redirect_target;
        end else if (hit) begin
          out_instr_d = pc_q[2] ? line_data_q[63:32] : line_data_q[31:0];
          out_pc_d    = pc_q;
          state_d     = StHold;
        end else begin
          araddr_d = ADDR_WIDTH'({pc_q[63:3], 3'b000});
          state_d  = StAr;
        end
      end
      StAr: begin
        if (redirect_valid) begin
          pc_d = redirect_target;
          // The address handshake may complete in the same cycle; then only the beat remains.
          state_d = m_axi_arready ? StDrain : StArKill;
        end else if (m_axi_arready) begin
          state_d = StR;
        end
      end
      StR: begin
        if (redirect_valid) begin
          pc_d    = redirect_target;
          state_d = m_axi_rvalid ? StLookup : StDrain;
        end else if (m_axi_rvalid) begin
          if (m_axi_rresp == 2'b00) begin
            line_valid_d = 1'b1;
            line_tag_d   = pc_q[63:3];
            line_data_d  = m_axi_rdata[63:0];
            out_instr_d  = pc_q[2] ? m_axi_rdata[63:32] : m_axi_rdata[31:0];
            out_pc_d     = pc_q;
            state_d      = StHold;
          end else begin
            line_valid_d = 1'b0;
            state_d      = StErr;
          end
        end
      end
      StHold: begin
        if (redirect_valid) begin
          pc_d    = redirect_target;
          state_d = StLookup;
        end else if (out_ready) begin
          pc_d = pc_plus4;
          if (!pc_q[2]) begin
            // Upper word of the same line: serve it back-to-back from the buffer.
            out_instr_d = line_data_q[63:32];
            out_pc_d    = pc_plus4;
          end else begin
            state_d = StLookup;
          end
        end
      end
      StArKill: begin
        if (redirect_valid) begin
          pc_d = redirect_target;
        end
        if (m_axi_arready) begin
          state_d = StDrain;
        end
      end
      StDrain: begin
        if (redirect_valid) begin
          pc_d = redirect_target;
        end
        if (m_axi_rvalid) begin
          state_d = StLookup;
        end
      end
      StErr: begin
        if (redirect_valid) begin
          pc_d    = redirect_target;
          state_d = StLookup;
        end
      end
      default: state_d = StInit;
    endcase
  end

  // State and datapath registers, cleared asynchronously
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= StInit;
      pc_q         <= '0;
      line_valid_q <= 1'b0;
      line_tag_q   <= '0;
      line_data_q  <= '0;
      out_instr_q  <= '0;
      out_pc_q     <= '0;
      araddr_q     <= '0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      line_valid_q <= line_valid_d;
      line_tag_q   <= line_tag_d;
      line_data_q  <= line_data_d;
      out_instr_q  <= out_instr_d;
      out_pc_q     <= out_pc_d;
      araddr_q     <= araddr_d;
    end
  end

  // Handshake outputs decode straight from the state so reset drops them immediately
  always_comb begin
    out_valid     = (state_q == StHold);
    fetch_error   = (state_q == StErr);
    m_axi_arvalid = (state_q == StAr) || (state_q == StArKill);
    m_axi_rready  = (state_q == StR) || (state_q == StDrain);
    out_instr     = out_instr_q;
    out_pc        = out_pc_q;
    m_axi_araddr  = araddr_q;
    m_axi_arid    = '0;
    m_axi_arlen   = 8'd0;
    m_axi_arsize  = 3'b011;
    m_axi_arburst = 2'b01;
  end

endmodule

// File: tb/tb_fetch_line_unit.sv
// Bench for fetch_line_unit: an AXI memory responder with random latencies and a
// PC/instruction-stream reference model (expected PC, single-line buffer contents,
// error flag) checked every cycle, plus directed scenarios.
module tb_fetch_line_unit;

  localparam int unsigned IdW = 13;

  logic           clk = 1'b0;
  logic           reset;
  logic [63:0]    entry;
  logic           redirect_valid;
  logic [63:0]    redirect_pc;
  logic           out_valid;
  logic           out_ready;
  logic [31:0]    out_instr;
  logic [63:0]    out_pc;
  logic           fetch_error;
  logic [IdW-1:0] m_axi_arid;
  logic [63:0]    m_axi_araddr;
  logic [7:0]     m_axi_arlen;
  logic [2:0]     m_axi_arsize;
  logic [1:0]     m_axi_arburst;
  logic           m_axi_arvalid;
  logic           m_axi_arready;
  logic [IdW-1:0] m_axi_rid;
  logic [63:0]    m_axi_rdata;
  logic [1:0]     m_axi_rresp;
  logic           m_axi_rlast;
  logic           m_axi_rvalid;
  logic           m_axi_rready;

  fetch_line_unit #(
    .ID_WIDTH  (IdW),
    .ADDR_WIDTH(64),
    .DATA_WIDTH(64)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .entry         (entry),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_instr     (out_instr),
    .out_pc        (out_pc),
    .fetch_error   (fetch_error),
    .m_axi_arid    (m_axi_arid),
    .m_axi_araddr  (m_axi_araddr),
    .m_axi_arlen   (m_axi_arlen),
    .m_axi_arsize  (m_axi_arsize),
    .m_axi_arburst (m_axi_arburst),
    .m_axi_arvalid (m_axi_arvalid),
    .m_axi_arready (m_axi_arready),
    .m_axi_rid     (m_axi_rid),
    .m_axi_rdata   (m_axi_rdata),
    .m_axi_rresp   (m_axi_rresp),
    .m_axi_rlast   (m_axi_rlast),
    .m_axi_rvalid  (m_axi_rvalid),
    .m_axi_rready  (m_axi_rready)
  );

  always #5 clk = ~clk;

  int checks, failures, cyc;

  // Reference model
  logic [63:0] exp_pc;
  bit          line_ok;
  logic [60:0] line_tag;
  bit          err_state, exp_valid_now, exp_invalid_now, hold_now;
  logic [63:0] hold_pc;
  logic [31:0] hold_instr;

  // Memory responder state and knobs
  bit          ar_wait_prev, r_pending, killed, err_force;
  logic [63:0] ar_addr_prev, r_addr;
  logic [60:0] ar_line;
  logic [1:0]  r_resp;
  int          ar_left, r_left, ar_hi, last_ar_hi;
  int          ar_lat_min, ar_lat_max, r_lat_min, r_lat_max, p_err;

  // Logs for directed scenarios
  logic [63:0] ar_log[$];
  logic [63:0] xfer_pc[$];
  logic [31:0] xfer_instr[$];
  int          xfer_cyc[$];
  int          first_valid_cyc, first_beat_cyc;
  int          ar0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [63:0] mem_line(input logic [63:0] a);
    logic [63:0] la;
    la = {a[63:3], 3'b000};
    if (la == 64'h8000_0000) return 64'h0000_0013_0000_0093;
    return {la[31:0] ^ 32'h1357_9bdf, la[63:32] ^ {la[15:0], la[31:16]} ^ 32'h2468_ace0};
  endfunction

  function automatic logic [31:0] exp_instr(input logic [63:0] pc);
    logic [63:0] l;
    l = mem_line(pc);
    return pc[2] ? l[63:32] : l[31:0];
  endfunction

  // One clock: called at a negedge with out_ready/redirect already set by the caller.
  task automatic cycle();
    bit beat, live, issue, r_busy, xfer;
    if (exp_valid_now) check_eq("miss_latency_valid", out_valid, 1);
    if (exp_invalid_now) check_eq("valid_drop", out_valid, 0);
    if (hold_now) begin
      check_eq("hold_valid", out_valid, 1);
      check_eq("hold_pc", out_pc, hold_pc);
      check_eq("hold_instr", out_instr, hold_instr);
    end
    check_eq("fetch_error", fetch_error, err_state);
    if (err_state) check_eq("err_no_valid", out_valid, 0);
    if (out_valid && first_valid_cyc < 0) first_valid_cyc = cyc;

    // Read-data channel
    r_busy = r_pending;
    beat = 0;
    live = 0;
    m_axi_rvalid = 0;
    m_axi_rdata  = '0;
    m_axi_rresp  = 2'b00;
    if (r_pending) begin
      if (r_left == 0) begin
        beat = 1;
        m_axi_rvalid = 1;
        m_axi_rdata  = mem_line(r_addr);
        m_axi_rresp  = r_resp;
        check_eq("rready", m_axi_rready, 1);
        live = !killed && !redirect_valid;
        r_pending = 0;
        if (live && r_resp == 2'b00) begin
          line_ok  = 1;
          line_tag = ar_line;
          if (first_beat_cyc < 0) first_beat_cyc = cyc;
        end
        if (live && r_resp != 2'b00) line_ok = 0;
      end else begin
        r_left--;
      end
    end

    // Read-address channel
    issue = m_axi_arvalid && !ar_wait_prev;
    m_axi_arready = 0;
    if (ar_wait_prev) begin
      check_eq("arvalid_hold", m_axi_arvalid, 1);
      check_eq("araddr_hold", m_axi_araddr, ar_addr_prev);
    end
    if (m_axi_arvalid) begin
      check_eq("arlen", m_axi_arlen, 0);
      check_eq("arsize", m_axi_arsize, 3'b011);
      check_eq("arburst", m_axi_arburst, 2'b01);
      check_eq("arid", m_axi_arid, 0);
      if (issue) begin
        check_eq("one_outstanding", r_busy, 0);
        check_eq("ar_addr", m_axi_araddr, {exp_pc[63:3], 3'b000});
        check_eq("ar_on_hit", line_ok && (line_tag == exp_pc[63:3]), 0);
        ar_log.push_back(m_axi_araddr);
        ar_line = exp_pc[63:3];
        killed  = 0;
        ar_hi   = 0;
        ar_left = $urandom_range(ar_lat_max, ar_lat_min);
      end
      ar_hi++;
      if (ar_left == 0) begin
        m_axi_arready = 1;
        r_pending  = 1;
        r_addr     = m_axi_araddr;
        r_left     = $urandom_range(r_lat_max, r_lat_min);
        last_ar_hi = ar_hi;
        if (err_force) begin
          r_resp = 2'b10;
          err_force = 0;
        end else if ($urandom_range(99, 0) < p_err) begin
          r_resp = 2'($urandom_range(3, 1));
        end else begin
          r_resp = 2'b00;
        end
      end else begin
        ar_left--;
      end
    end
    ar_wait_prev = m_axi_arvalid && !m_axi_arready;
    ar_addr_prev = m_axi_araddr;
    if (redirect_valid && (m_axi_arvalid || r_busy)) killed = 1;

    // Instruction stream; a transfer coinciding with a redirect is dropped
    xfer = out_valid && out_ready && !redirect_valid;
    if (xfer) begin
      check_eq("out_pc", out_pc, exp_pc);
      check_eq("out_instr", out_instr, exp_instr(exp_pc));
      xfer_pc.push_back(out_pc);
      xfer_instr.push_back(out_instr);
      xfer_cyc.push_back(cyc);
      exp_pc = exp_pc + 64'd4;
    end

    exp_valid_now   = live && (r_resp == 2'b00);
    exp_invalid_now = redirect_valid || (beat && !live);
    hold_now        = out_valid && !out_ready && !redirect_valid;
    hold_pc         = out_pc;
    hold_instr      = out_instr;
    if (redirect_valid) begin
      exp_pc    = {redirect_pc[63:2], 2'b00};
      err_state = 0;
    end else if (live && r_resp != 2'b00) begin
      err_state = 1;
    end
    cyc++;
    @(negedge clk);
  endtask

  task automatic do_reset(input logic [63:0] e);
    reset          = 0;
    entry          = e;
    redirect_valid = 0;
    redirect_pc    = '0;
    m_axi_arready  = 0;
    m_axi_rvalid   = 0;
    m_axi_rdata    = '0;
    m_axi_rresp    = 2'b00;
    exp_pc         = {e[63:2], 2'b00};
    line_ok        = 0;
    err_state      = 0;
    exp_valid_now  = 0;
    exp_invalid_now = 0;
    hold_now       = 0;
    ar_wait_prev   = 0;
    r_pending      = 0;
    killed         = 0;
    err_force      = 0;
    ar_log.delete();
    xfer_pc.delete();
    xfer_instr.delete();
    xfer_cyc.delete();
    first_valid_cyc = -1;
    first_beat_cyc  = -1;
    repeat (2) @(negedge clk);
    check_eq("rst_out_valid", out_valid, 0);
    check_eq("rst_out_instr", out_instr, 0);
    check_eq("rst_out_pc", out_pc, 0);
    check_eq("rst_fetch_error", fetch_error, 0);
    check_eq("rst_arvalid", m_axi_arvalid, 0);
    check_eq("rst_rready", m_axi_rready, 0);
    check_eq("rst_araddr", m_axi_araddr, 0);
    check_eq("rst_arsize", m_axi_arsize, 3'b011);
    check_eq("rst_arburst", m_axi_arburst, 2'b01);
    reset = 1;
    cyc = 0;
  endtask

  task automatic set_lat(input int a_min, input int a_max, input int r_min, input int r_max);
    ar_lat_min = a_min;
    ar_lat_max = a_max;
    r_lat_min  = r_min;
    r_lat_max  = r_max;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    checks      = 0;
    failures    = 0;
    cyc         = 0;
    p_err       = 0;
    out_ready   = 1;
    m_axi_rid   = '0;
    m_axi_rlast = 1;
    set_lat(0, 0, 0, 0);

    // Straight-line fetch from entry: two words from one line, then the next line.
    do_reset(64'h8000_0000);
    for (int i = 0; i < 100 && xfer_pc.size() < 2; i++) cycle();
    for (int i = 0; i < 100 && ar_log.size() < 2; i++) cycle();
    check_eq("a_progress", (xfer_pc.size() >= 2) && (ar_log.size() >= 2), 1);
    if (xfer_pc.size() >= 2 && ar_log.size() >= 2) begin
      check_eq("a_ar0", ar_log[0], 64'h8000_0000);
      check_eq("a_pc0", xfer_pc[0], 64'h8000_0000);
      check_eq("a_in0", xfer_instr[0], 32'h0000_0093);
      check_eq("a_pc1", xfer_pc[1], 64'h8000_0004);
      check_eq("a_in1", xfer_instr[1], 32'h0000_0013);
      check_eq("a_b2b", xfer_cyc[1] - xfer_cyc[0], 1);
      check_eq("a_ar1", ar_log[1], 64'h8000_0008);
      check_eq("a_latency", 64'(first_valid_cyc), 64'(first_beat_cyc + 1));
    end

    // Address channel stalled for five cycles.
    set_lat(5, 5, 0, 0);
    do_reset(64'h8000_0000);
    for (int i = 0; i < 100 && xfer_pc.size() < 1; i++) cycle();
    check_eq("b_ar_cycles", last_ar_hi, 6);
    check_eq("b_latency", 64'(first_valid_cyc), 64'(first_beat_cyc + 1));

    // Redirect while the address phase is still waiting for arready.
    set_lat(3, 3, 2, 2);
    do_reset(64'h8000_0000);
    for (int i = 0; i < 20 && !m_axi_arvalid; i++) cycle();
    redirect_valid = 1;
    redirect_pc    = 64'h8000_0100;
    cycle();
    redirect_valid = 0;
    for (int i = 0; i < 100 && xfer_pc.size() < 1; i++) cycle();
    check_eq("c_ar_count", ar_log.size(), 2);
    if (ar_log.size() >= 2 && xfer_pc.size() >= 1) begin
      check_eq("c_ar1", ar_log[1], 64'h8000_0100);
      check_eq("c_pc0", xfer_pc[0], 64'h8000_0100);
    end

    // Bus error, then recovery by redirect into the same (now invalid) line.
    set_lat(0, 0, 0, 0);
    do_reset(64'h8000_0000);
    err_force = 1;
    repeat (30) cycle();
    check_eq("d_err", fetch_error, 1);
    check_eq("d_no_out", xfer_pc.size(), 0);
    redirect_valid = 1;
    redirect_pc    = 64'h8000_0004;
    cycle();
    redirect_valid = 0;
    for (int i = 0; i < 100 && xfer_pc.size() < 1; i++) cycle();
    check_eq("d_err_clr", fetch_error, 0);
    check_eq("d_ar_count", ar_log.size(), 2);
    if (ar_log.size() >= 2 && xfer_pc.size() >= 1) begin
      check_eq("d_ar1", ar_log[1], 64'h8000_0000);
      check_eq("d_pc0", xfer_pc[0], 64'h8000_0004);
    end

    // Consumer back-pressure, then redirect into the buffered line.
    do_reset(64'h8000_0000);
    out_ready = 0;
    for (int i = 0; i < 30 && !out_valid; i++) cycle();
    ar0 = ar_log.size();
    repeat (10) cycle();
    check_eq("e_no_ar", ar_log.size(), ar0);
    check_eq("e_valid", out_valid, 1);
    check_eq("e_pc", out_pc, 64'h8000_0000);
    redirect_valid = 1;
    redirect_pc    = 64'h8000_0004;
    cycle();
    redirect_valid = 0;
    cycle();
    check_eq("e_hit_valid", out_valid, 1);
    check_eq("e_hit_pc", out_pc, 64'h8000_0004);
    check_eq("e_hit_instr", out_instr, 32'h0000_0013);
    check_eq("e_hit_no_ar", ar_log.size(), ar0);
    out_ready = 1;
    repeat (5) cycle();

    // Reset in the middle of a read, then restart from an unaligned entry.
    set_lat(0, 0, 8, 8);
    do_reset(64'h8000_0000);
    for (int i = 0; i < 30 && !m_axi_rready; i++) cycle();
    #2 reset = 0;
    #1;
    check_eq("f_arvalid", m_axi_arvalid, 0);
    check_eq("f_rready", m_axi_rready, 0);
    check_eq("f_out_valid", out_valid, 0);
    set_lat(0, 2, 0, 2);
    do_reset(64'h8000_0042);
    for (int i = 0; i < 100 && xfer_pc.size() < 1; i++) cycle();
    check_eq("f_refetch", xfer_pc.size() >= 1 && ar_log.size() >= 1, 1);
    if (xfer_pc.size() >= 1 && ar_log.size() >= 1) begin
      check_eq("f_ar0", ar_log[0], 64'h8000_0040);
      check_eq("f_pc0", xfer_pc[0], 64'h8000_0040);
    end

    // Randomized traffic: back-pressure, redirects (incl. across the 64-bit wrap), errors.
    set_lat(0, 4, 0, 4);
    p_err = 8;
    do_reset(64'h8000_0000);
    for (int i = 0; i < 4000; i++) begin
      out_ready      = ($urandom_range(99, 0) < 75);
      redirect_valid = 0;
      if (cyc >= 1 && ($urandom_range(99, 0) < (err_state ? 30 : 4))) begin
        redirect_valid = 1;
        if ($urandom_range(15, 0) == 0)
          redirect_pc = 64'hFFFF_FFFF_FFFF_FFF0 + 64'($urandom_range(15, 0));
        else
          redirect_pc = 64'h8000_0000 + 64'($urandom_range(1023, 0));
      end
      cycle();
    end
    redirect_valid = 0;
    check_eq("random_progress", xfer_pc.size() > 200, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
